// File: rtl/video_timing_gen_if.sv
// Raster timing bundle: realign request in, position and sync/status out.
interface video_timing_gen_if;
  logic        vreset;
  logic [11:0] hcnt;
  logic [9:0]  vcnt;
  logic        hs;
  logic        vs;
  logic        de;
  logic        sof;
  logic        locked;
  logic [7:0]  resync_cnt;

  modport master (
    input  vreset,
    output hcnt, vcnt, hs, vs, de, sof, locked, resync_cnt
  );

  modport slave (
    output vreset,
    input  hcnt, vcnt, hs, vs, de, sof, locked, resync_cnt
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator with analyzer-driven realign and phase-error counting.
// state       | meaning
// ST_UNLOCKED | no vreset rising edge seen since reset
// ST_LOCKED   | at least one vreset rising edge accepted
module video_timing_gen #(
  parameter int H_ACTIVE = 720,
  parameter int H_FP     = 12,
  parameter int H_SYNC   = 64,
  parameter int H_BP     = 68,
  parameter int V_ACTIVE = 576,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 39
) (
  input  logic               clk,
  input  logic               reset,
  video_timing_gen_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic [0:0] {ST_UNLOCKED, ST_LOCKED} lock_state_t;

  lock_state_t r_state;
  lock_state_t w_state_next;

  logic [11:0] r_hcnt;
  logic [9:0]  r_vcnt;
  logic        r_hs;
  logic        r_vs;
  logic        r_de;
  logic        r_sof;
  logic [7:0]  r_resync_cnt;
  logic        r_vreset_d;

  logic [11:0] w_hnext;
  logic [9:0]  w_vnext;
  logic        w_rise;
  logic        w_in_phase;

  assign w_rise     = vif.vreset & ~r_vreset_d;
  assign w_in_phase = (r_hcnt == H_LAST) && (r_vcnt == V_LAST);

  // vreset forces the next position to the first active pixel every cycle it is high
  always_comb begin
    w_hnext = r_hcnt + 12'd1;
    w_vnext = r_vcnt;
    if (vif.vreset) begin
      w_hnext = '0;
      w_vnext = '0;
    end else if (r_hcnt == H_LAST) begin
      w_hnext = '0;
      w_vnext = (r_vcnt == V_LAST) ? '0 : r_vcnt + 10'd1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_UNLOCKED: if (w_rise) w_state_next = ST_LOCKED;
      ST_LOCKED:   w_state_next = ST_LOCKED;
      default:     w_state_next = ST_UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_UNLOCKED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Decodes use the next position so flags line up with the counters they describe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hcnt       <= H_LAST;
      r_vcnt       <= V_LAST;
      r_hs         <= 1'b1;
      r_vs         <= 1'b1;
      r_de         <= 1'b0;
      r_sof        <= 1'b0;
      r_resync_cnt <= '0;
      r_vreset_d   <= 1'b0;
    end else begin
      r_hcnt     <= w_hnext;
      r_vcnt     <= w_vnext;
      r_hs       <= !((w_hnext >= HS_START) && (w_hnext <= HS_END));
      r_vs       <= !((w_vnext >= VS_START) && (w_vnext <= VS_END));
      r_de       <= (w_hnext < H_ACT) && (w_vnext < V_ACT);
      r_sof      <= (w_hnext == 12'd0) && (w_vnext == 10'd0);
      r_vreset_d <= vif.vreset;
      if (w_rise && !w_in_phase && (r_resync_cnt != 8'hFF)) begin
        r_resync_cnt <= r_resync_cnt + 8'd1;
      end
    end
  end

  assign vif.hcnt       = r_hcnt;
  assign vif.vcnt       = r_vcnt;
  assign vif.hs         = r_hs;
  assign vif.vs         = r_vs;
  assign vif.de         = r_de;
  assign vif.sof        = r_sof;
  assign vif.locked     = (r_state == ST_LOCKED);
  assign vif.resync_cnt = r_resync_cnt;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: a linear frame-position model predicts every output cycle.
module tb_video_timing_gen;
  localparam int HA = 40, HF = 4, HS = 6, HB = 6;
  localparam int VA = 20, VF = 2, VS = 3, VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic vreset = 1'b0;
  always #5 clk = ~clk;

  video_timing_gen_if vif();
  assign vif.vreset = vreset;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .vif   (vif.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [35:0] exp_q[$];
  int  m_p      = 0;
  bit  m_locked = 0;
  int  m_resync = 0;
  bit  m_prev   = 0;
  bit  m_started = 0;

  bit agg_en = 0;
  bit agg_armed = 0;
  int agg_cnt = 0, agg_de = 0, agg_vs = 0, agg_frames = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] expect_at(input int p, input bit lk, input int rs);
    int h;
    int v;
    bit e_hs;
    bit e_vs;
    bit e_de;
    bit e_sof;
    h     = p % HT;
    v     = p / HT;
    e_hs  = !(h >= HA + HF && h < HA + HF + HS);
    e_vs  = !(v >= VA + VF && v < VA + VF + VS);
    e_de  = (h < HA) && (v < VA);
    e_sof = (p == 0);
    return {12'(h), 10'(v), e_hs, e_vs, e_de, e_sof, lk, 8'(rs)};
  endfunction

  // Reference model: position is a single index into the frame
  always @(posedge clk) begin
    if (reset) begin
      m_p = FRAME - 1; m_locked = 0; m_resync = 0; m_prev = 0; m_started = 1;
      exp_q.push_back({12'(HT - 1), 10'(VT - 1), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    end else if (m_started) begin
      if (vreset && !m_prev) begin
        m_locked = 1;
        if (m_p != FRAME - 1 && m_resync < 255) m_resync++;
      end
      m_p    = vreset ? 0 : (m_p + 1) % FRAME;
      m_prev = vreset;
      exp_q.push_back(expect_at(m_p, m_locked, m_resync));
    end
  end

  // Monitor: pop one expectation per presented output cycle; also frame statistics
  always @(posedge clk) begin
    logic [35:0] e;
    logic [35:0] a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {vif.hcnt, vif.vcnt, vif.hs, vif.vs, vif.de, vif.sof, vif.locked, vif.resync_cnt};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t got h=%0d v=%0d hs=%b vs=%b de=%b sof=%b lk=%b rs=%0d expected h=%0d v=%0d hs=%b vs=%b de=%b sof=%b lk=%b rs=%0d",
                 $time, a[35:24], a[23:14], a[13], a[12], a[11], a[10], a[9], a[7:0],
                 e[35:24], e[23:14], e[13], e[12], e[11], e[10], e[9], e[7:0]);
      end
    end
    if (!agg_en) begin
      agg_armed = 0;
    end else begin
      if (vif.sof === 1'b1) begin
        if (agg_armed) begin
          check("sof_interval", agg_cnt, FRAME);
          check("de_per_frame", agg_de, HA * VA);
          check("vs_low_per_frame", agg_vs, VS * HT);
          agg_frames++;
        end
        agg_armed = 1;
        agg_cnt = 0; agg_de = 0; agg_vs = 0;
      end
      agg_cnt++;
      if (vif.de === 1'b1) agg_de++;
      if (vif.vs === 1'b0) agg_vs++;
    end
  end

  task automatic wait_pos(input int h, input int v);
    int n;
    n = 0;
    while (m_p != v * HT + h && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check("wait_pos_reached", m_p, v * HT + h);
  endtask

  task automatic pulse();
    vreset = 1'b1;
    @(negedge clk);
    vreset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    agg_en = 1;
    @(negedge clk);
    check("first_hcnt", int'(vif.hcnt), 0);
    check("first_sof", int'(vif.sof), 1);
    repeat (2 * FRAME + 10) @(negedge clk);
    agg_en = 0;
    check("frames_measured", agg_frames, 2);

    wait_pos(10, 5);
    pulse();
    check("oop_resync", int'(vif.resync_cnt), 1);
    check("oop_locked", int'(vif.locked), 1);

    wait_pos(HT - 1, VT - 1);
    pulse();
    check("inphase_resync", int'(vif.resync_cnt), 1);

    wait_pos(3, 3);
    vreset = 1'b1;
    repeat (3) @(negedge clk);
    vreset = 1'b0;
    check("hold_h", int'(vif.hcnt), 0);
    check("hold_resync", int'(vif.resync_cnt), 2);
    @(negedge clk);
    check("hold_resume_h", int'(vif.hcnt), 1);
    check("hold_resume_v", int'(vif.vcnt), 0);

    repeat (300) begin
      vreset = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    vreset = 1'b0;
    @(negedge clk);

    repeat (260) begin
      vreset = 1'b1;
      @(negedge clk);
      vreset = 1'b0;
      repeat (2) @(negedge clk);
    end
    check("resync_saturated", int'(vif.resync_cnt), 255);

    repeat (20) @(negedge clk);
    reset  = 1'b1;
    vreset = 1'b1;
    @(negedge clk);
    check("rst_hcnt", int'(vif.hcnt), HT - 1);
    check("rst_resync", int'(vif.resync_cnt), 0);
    check("rst_locked", int'(vif.locked), 0);
    @(negedge clk);
    reset  = 1'b0;
    vreset = 1'b0;
    @(negedge clk);
    check("post_rst_sof", int'(vif.sof), 1);
    check("post_rst_de", int'(vif.de), 1);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
